mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the RV32I pipeline. Registers the EX-stage outputs into the E->M pipeline register.
//  Executes loads/stores on a req/ack data-memory bus with byte enables and load sign/zero extension.
//  Detects misaligned accesses and bus timeouts. Drives StallM back to the hazard unit while a bus
//  transaction is outstanding, and feeds ALUResultM to EX forwarding.
// PARAMETERS
//  MAX_WAIT  255  max cycles in WAIT before a bus timeout is declared (1..255; counter 8 bits)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset (asserted at 0)
//  RegWriteE    in   1   EX control: register write
//  ResultSrcE   in   2   EX control: 00 ALU, 01 load, 10 PC+4
//  MemWriteE    in   1   EX control: store
//  funct3E      in   3   load/store size/sign
//  ALUResultE   in   32  effective address / ALU result
//  WriteDataE   in   32  forwarded rs2 store data
//  RdE          in   5   destination register
//  PCPlus4E     in   32  link value
//  dmem_req     out  1   bus request
//  dmem_we      out  1   1 = write
//  dmem_addr    out  32  word-aligned address ({ALUResultM[31:2],2'b00})
//  dmem_wdata   out  32  store data, lane-shifted
//  dmem_be      out  4   byte enables
//  dmem_ack     in   1   transaction complete (may assert in the same cycle as req)
//  dmem_rdata   in   32  read word, valid when dmem_ack=1
//  RegWriteM    out  1   to WB; forced 0 on misalign/timeout
//  ResultSrcM   out  2   to WB
//  RdM          out  5   to WB and hazard unit
//  ALUResultM   out  32  to WB and EX forwarding
//  PCPlus4M     out  32  to WB
//  ReadDataM    out  32  extended load data; valid only in the ack cycle
//  StallM       out  1   hold F/D/E/M registers
//  MisalignM    out  1   1-cycle pulse: misaligned access suppressed
//  BusErrM      out  1   1-cycle pulse: timeout, access abandoned
// BEHAVIOUR
//  - Reset (reset=0): all M registers 0, state IDLE, wait counter 0.
//    All outputs 0 (dmem_req deasserts immediately). Reset mid-WAIT abandons the transaction silently.
//  - E->M register: loads on every rising edge when StallM=0. Holds when StallM=1.
//  - memop = ResultSrcM==01 | MemWriteM.
//    Misaligned when: halfword with addr[0]=1, or word with addr[1:0]!=0.
//  - States:
//    IDLE: if memop & aligned -> dmem_req=1. If dmem_ack -> stay IDLE, StallM=0 (zero-wait).
//          Otherwise -> WAIT, StallM=1. If memop & misaligned -> no req, MisalignM=1, RegWriteM=0, no stall.
//    WAIT: req/we/addr/wdata/be held stable, StallM=1, counter++.
//          On dmem_ack -> IDLE, StallM=0 this cycle (pipeline advances on this edge).
//          On counter==MAX_WAIT-1 without ack -> IDLE, BusErrM=1, RegWriteM=0, StallM=0.
//          Ack takes priority over timeout in the same cycle.
//  - Store lanes (funct3):
//    SB: be=0001<<addr[1:0], wdata={4{data[7:0]}}.
//    SH: be=0011<<addr[1:0], wdata={2{data[15:0]}}.
//    SW: be=1111.
//  - Loads: be=1111, dmem_we=0. Byte/half selected by addr[1:0].
//    LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
//    Invalid funct3 (011,110,111): treated as word access.
//  - Non-memop: dmem_req=0, StallM=0, ReadDataM=0.
//  - Latency: zero-wait bus = 1 cycle in M, no stall. N-wait bus = N stall cycles.
// TESTING
//  1 SW addr=0x100 data=0xDEADBEEF, ack same cycle -> req=1 we=1 be=1111 wdata=0xDEADBEEF, StallM never 1.
//  2 LB addr=0x203, rdata=0x80000000, ack after 3 cycles -> StallM=1 for 3 cycles; ReadDataM=0xFFFFFF80 in ack cycle; LBU gives 0x00000080.
//  3 SH addr=0x102 data=0x1234 -> be=1100, wdata=0x12341234.
//  4 LW addr=0x101 -> no req, MisalignM=1 for 1 cycle, RegWriteM=0.
//  5 LW, ack never asserted -> StallM=1 for MAX_WAIT cycles, then BusErrM pulse, req drops, pipeline resumes.
//  6 reset=0 during WAIT -> req=0 and StallM=0 asynchronously; after release, state IDLE and outputs 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline.
// Holds the E->M pipeline register. Runs loads and stores on a req/ack data
// bus, with byte enables and load extension. Flags misaligned accesses and
// bus timeouts, and stalls the pipeline while a transaction is outstanding.
module mem_access_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteE,
    input  logic [1:0]  ResultSrcE,
    input  logic        MemWriteE,
    input  logic [2:0]  funct3E,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  RdE,
    input  logic [31:0] PCPlus4E,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        RegWriteM,
    output logic [1:0]  ResultSrcM,
    output logic [4:0]  RdM,
    output logic [31:0] ALUResultM,
    output logic [31:0] PCPlus4M,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    // The counter runs 0..MAX_WAIT-1 while in WAIT; the last value is the timeout cycle.
    localparam logic [7:0] LP_LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [7:0]  r_waitCnt;

    logic        r_RegWrite;
    logic [1:0]  r_ResultSrc;
    logic        r_MemWrite;
    logic [2:0]  r_funct3;
    logic [31:0] r_ALUResult;
    logic [31:0] r_WriteData;
    logic [4:0]  r_Rd;
    logic [31:0] r_PCPlus4;

    logic        w_memop;
    logic        w_sizeByte;
    logic        w_sizeHalf;
    logic        w_misaligned;
    logic        w_timeout;
    logic        w_req;
    logic        w_stall;
    logic        w_misalignPulse;
    logic        w_busErrPulse;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_laneShift;
    logic [15:0] w_half;
    logic [31:0] w_loadExt;

    // Access size comes from funct3[1:0]; anything other than byte/half is a word access.
    assign w_memop      = (r_ResultSrc == 2'b01) | r_MemWrite;
    assign w_sizeByte   = (r_funct3[1:0] == 2'b00);
    assign w_sizeHalf   = (r_funct3[1:0] == 2'b01);
    assign w_misaligned = (w_sizeHalf & r_ALUResult[0]) |
                          (~w_sizeByte & ~w_sizeHalf & (r_ALUResult[1:0] != 2'b00));
    assign w_timeout    = (r_waitCnt == LP_LAST_WAIT);

    // E->M pipeline register, frozen while the bus transaction is outstanding
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_RegWrite  <= 1'b0;
            r_ResultSrc <= 2'b00;
            r_MemWrite  <= 1'b0;
            r_funct3    <= 3'b000;
            r_ALUResult <= 32'h0;
            r_WriteData <= 32'h0;
            r_Rd        <= 5'h0;
            r_PCPlus4   <= 32'h0;
        end else if (!w_stall) begin
            r_RegWrite  <= RegWriteE;
            r_ResultSrc <= ResultSrcE;
            r_MemWrite  <= MemWriteE;
            r_funct3    <= funct3E;
            r_ALUResult <= ALUResultE;
            r_WriteData <= WriteDataE;
            r_Rd        <= RdE;
            r_PCPlus4   <= PCPlus4E;
        end
    end

    // State register plus wait counter; the counter restarts every time WAIT is entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_waitCnt <= 8'h0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_WAIT) begin
                r_waitCnt <= r_waitCnt + 8'h1;
            end else begin
                r_waitCnt <= 8'h0;
            end
        end
    end

    // Next state: leave IDLE only for an aligned access not acked at once; ack beats timeout
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_memop && !w_misaligned && !dmem_ack) begin
                    w_nextState = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_ack || w_timeout) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Control outputs: request, stall, and the misalign / bus error pulses
    always_comb begin
        w_req           = 1'b0;
        w_stall         = 1'b0;
        w_misalignPulse = 1'b0;
        w_busErrPulse   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_memop) begin
                    if (w_misaligned) begin
                        w_misalignPulse = 1'b1;
                    end else begin
                        w_req   = 1'b1;
                        w_stall = ~dmem_ack;
                    end
                end
            end
            ST_WAIT: begin
                w_req = 1'b1;
                if (!dmem_ack) begin
                    if (w_timeout) begin
                        w_busErrPulse = 1'b1;
                    end else begin
                        w_stall = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Store lane placement; loads always fetch the whole word
    always_comb begin
        w_be    = 4'hF;
        w_wdata = r_WriteData;
        if (r_MemWrite) begin
            if (w_sizeByte) begin
                w_be    = 4'b0001 << r_ALUResult[1:0];
                w_wdata = {4{r_WriteData[7:0]}};
            end else if (w_sizeHalf) begin
                w_be    = 4'b0011 << r_ALUResult[1:0];
                w_wdata = {2{r_WriteData[15:0]}};
            end
        end
    end

    assign w_laneShift = dmem_rdata >> {r_ALUResult[1:0], 3'b000};
    assign w_half      = r_ALUResult[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    // Load extension; undefined funct3 codes behave as LW
    always_comb begin
        case (r_funct3)
            3'b000:  w_loadExt = {{24{w_laneShift[7]}}, w_laneShift[7:0]};
            3'b001:  w_loadExt = {{16{w_half[15]}}, w_half};
            3'b100:  w_loadExt = {24'h0, w_laneShift[7:0]};
            3'b101:  w_loadExt = {16'h0, w_half};
            default: w_loadExt = dmem_rdata;
        endcase
    end

    assign dmem_req   = w_req;
    assign dmem_we    = w_req & r_MemWrite;
    assign dmem_addr  = {r_ALUResult[31:2], 2'b00};
    assign dmem_wdata = (w_req & r_MemWrite) ? w_wdata : 32'h0;
    assign dmem_be    = w_req ? w_be : 4'h0;

    assign RegWriteM  = r_RegWrite & ~w_misalignPulse & ~w_busErrPulse;
    assign ResultSrcM = r_ResultSrc;
    assign RdM        = r_Rd;
    assign ALUResultM = r_ALUResult;
    assign PCPlus4M   = r_PCPlus4;
    assign ReadDataM  = (w_req & dmem_ack & ~r_MemWrite) ? w_loadExt : 32'h0;
    assign StallM     = w_stall;
    assign MisalignM  = w_misalignPulse;
    assign BusErrM    = w_busErrPulse;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed corner cases followed by random
// transactions, all judged against a transaction-level reference model.
module tb_mem_access_stage;

    localparam int MAX_WAIT = 255;
    localparam int NEVER    = -1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        RegWriteE = 1'b0;
    logic [1:0]  ResultSrcE = 2'b00;
    logic        MemWriteE = 1'b0;
    logic [2:0]  funct3E = 3'b000;
    logic [31:0] ALUResultE = 32'h0;
    logic [31:0] WriteDataE = 32'h0;
    logic [4:0]  RdE = 5'h0;
    logic [31:0] PCPlus4E = 32'h0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM;
    logic [31:0] PCPlus4M;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        BusErrM;

    int checkCount = 0;
    int errorCount = 0;

    mem_access_stage dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .MemWriteE  (MemWriteE),
        .funct3E    (funct3E),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .RdE        (RdE),
        .PCPlus4E   (PCPlus4E),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .RdM        (RdM),
        .ALUResultM (ALUResultM),
        .PCPlus4M   (PCPlus4M),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // One comparison: count it, and report it when the DUT disagrees with the model
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model: number of bytes moved by an access of this funct3
    function automatic int unsigned sizeBytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Reference model: byte enables (loads always read all four lanes)
    function automatic logic [3:0] expBe(input logic isStore, input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] mask;
        int unsigned n;
        if (!isStore) return 4'hF;
        n = sizeBytes(f3);
        mask = ((32'd1 << n) - 32'd1) << (addr % 32'd4);
        return mask[3:0];
    endfunction

    // Reference model: store data replicated across every lane of its size
    function automatic logic [31:0] expWdata(input logic [2:0] f3, input logic [31:0] data);
        int unsigned n;
        n = sizeBytes(f3);
        if (n == 1) return (data & 32'hFF) * 32'h01010101;
        if (n == 2) return (data & 32'hFFFF) * 32'h00010001;
        return data;
    endfunction

    // Reference model: load result, shifted down and extended arithmetically
    function automatic logic [31:0] expRead(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] v;
        int unsigned n;
        n = sizeBytes(f3);
        v = rdata >> (32'd8 * (addr % 32'd4));
        if (n == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFFFF00;
            return v;
        end
        if (n == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF0000;
            return v;
        end
        return rdata;
    endfunction

    // Present one instruction to E, let it reach M, then play the bus for it.
    // ackCycle counts cycles spent in M before ack (NEVER = no ack at all).
    task automatic applyStimulus(input logic regWrite, input logic [1:0] resSrc, input logic memWrite,
                                 input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] rd, input logic [31:0] pc4, input int ackCycle,
                                 input logic [31:0] rdata, output int stallCycles);
        logic memop;
        logic mis;
        logic access;
        logic timedOut;
        logic isLoad;
        int   endCycle;
        bit   done;
        memop    = (resSrc == 2'b01) || memWrite;
        isLoad   = memop && !memWrite;
        mis      = memop && ((addr % sizeBytes(f3)) != 0);
        access   = memop && !mis;
        timedOut = access && (ackCycle < 0 || ackCycle > MAX_WAIT);
        endCycle = !access ? 0 : (timedOut ? MAX_WAIT : ackCycle);

        @(negedge clk);
        RegWriteE  = regWrite;
        ResultSrcE = resSrc;
        MemWriteE  = memWrite;
        funct3E    = f3;
        ALUResultE = addr;
        WriteDataE = data;
        RdE        = rd;
        PCPlus4E   = pc4;
        dmem_ack   = 1'b0;
        @(posedge clk);

        stallCycles = 0;
        done = 0;
        for (int c = 0; c <= MAX_WAIT + 1 && !done; c++) begin
            @(negedge clk);
            if (c == 0) begin
                RegWriteE  = 1'b0;
                ResultSrcE = 2'b00;
                MemWriteE  = 1'b0;
                ALUResultE = 32'h0;
            end
            dmem_ack   = (c == ackCycle);
            dmem_rdata = (c == ackCycle) ? rdata : $urandom;
            #1;
            if (StallM) stallCycles++;
            if (c == 0) begin
                checkOutput("RdM", 32'(RdM), 32'(rd));
                checkOutput("ALUResultM", ALUResultM, addr);
                checkOutput("PCPlus4M", PCPlus4M, pc4);
                checkOutput("ResultSrcM", 32'(ResultSrcM), 32'(resSrc));
                checkOutput("misalign", 32'(MisalignM), 32'(mis));
                checkOutput("req", 32'(dmem_req), 32'(access));
                if (access) begin
                    checkOutput("we", 32'(dmem_we), 32'(memWrite));
                    checkOutput("addr", dmem_addr, addr & 32'hFFFFFFFC);
                    checkOutput("be", 32'(dmem_be), 32'(expBe(memWrite, f3, addr)));
                    if (memWrite) checkOutput("wdata", dmem_wdata, expWdata(f3, data));
                end
            end
            if (c < endCycle) begin
                checkOutput("stallWait", 32'(StallM), 32'd1);
                checkOutput("reqHeld", 32'(dmem_req), 32'd1);
                @(posedge clk);
            end else begin
                checkOutput("stallEnd", 32'(StallM), 32'd0);
                checkOutput("busErr", 32'(BusErrM), 32'(timedOut));
                checkOutput("RegWriteM", 32'(RegWriteM), 32'(regWrite && !mis && !timedOut));
                checkOutput("ReadDataM", ReadDataM,
                            (isLoad && access && !timedOut) ? expRead(f3, addr, rdata) : 32'h0);
                done = 1;
            end
        end

        // The following cycle holds a bubble: no request and no lingering pulses
        @(posedge clk);
        #1;
        checkOutput("reqAfter", 32'(dmem_req), 32'd0);
        checkOutput("pulseAfter", {30'h0, BusErrM, MisalignM}, 32'd0);
    endtask

    // Main sequence: reset, directed corner cases, mid-WAIT reset, random traffic
    initial begin
        int stalls;
        int kind;
        logic [2:0] loadCodes [8];
        logic [31:0] rAddr;
        logic [31:0] rData;
        logic [31:0] rRead;
        logic [31:0] rPc;
        logic [4:0]  rRd;
        logic [1:0]  rSrc;
        logic [2:0]  rF3;
        loadCodes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        #1;
        checkOutput("resetReq", 32'(dmem_req), 32'd0);
        checkOutput("resetStall", 32'(StallM), 32'd0);
        checkOutput("resetRegWrite", 32'(RegWriteM), 32'd0);
        checkOutput("resetALU", ALUResultM, 32'h0);
        checkOutput("resetRead", ReadDataM, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(1'b0, 2'b00, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 32'h4, 0, 32'h0, stalls);
        checkOutput("swStalls", 32'(stalls), 32'd0);
        applyStimulus(1'b1, 2'b01, 1'b0, 3'b000, 32'h203, 32'h0, 5'd5, 32'h8, 3, 32'h80000000, stalls);
        checkOutput("lbStalls", 32'(stalls), 32'd3);
        applyStimulus(1'b1, 2'b01, 1'b0, 3'b100, 32'h203, 32'h0, 5'd6, 32'hC, 3, 32'h80000000, stalls);
        checkOutput("lbuStalls", 32'(stalls), 32'd3);
        applyStimulus(1'b0, 2'b00, 1'b1, 3'b001, 32'h102, 32'h1234, 5'd0, 32'h10, 1, 32'h0, stalls);
        applyStimulus(1'b1, 2'b01, 1'b0, 3'b010, 32'h101, 32'h0, 5'd7, 32'h14, 0, 32'h0, stalls);
        checkOutput("misStalls", 32'(stalls), 32'd0);
        applyStimulus(1'b1, 2'b01, 1'b0, 3'b010, 32'h300, 32'h0, 5'd8, 32'h18, NEVER, 32'h0, stalls);
        checkOutput("timeoutStalls", 32'(stalls), 32'(MAX_WAIT));
        applyStimulus(1'b1, 2'b01, 1'b0, 3'b001, 32'h302, 32'h0, 5'd9, 32'h1C, MAX_WAIT, 32'h8001_7FFF, stalls);
        checkOutput("lateAckStalls", 32'(stalls), 32'(MAX_WAIT));

        // Reset in the middle of a WAIT must drop req and stall immediately
        @(negedge clk);
        RegWriteE  = 1'b1;
        ResultSrcE = 2'b01;
        funct3E    = 3'b010;
        ALUResultE = 32'h40;
        RdE        = 5'd3;
        dmem_ack   = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        RegWriteE  = 1'b0;
        ResultSrcE = 2'b00;
        ALUResultE = 32'h0;
        RdE        = 5'd0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midResetReq", 32'(dmem_req), 32'd0);
        checkOutput("midResetStall", 32'(StallM), 32'd0);
        checkOutput("midResetALU", ALUResultM, 32'h0);
        checkOutput("midResetRd", 32'(RdM), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postResetReq", 32'(dmem_req), 32'd0);
        checkOutput("postResetStall", 32'(StallM), 32'd0);
        applyStimulus(1'b1, 2'b01, 1'b0, 3'b101, 32'h46, 32'h0, 5'd4, 32'h20, 0, 32'hBEEF_1234, stalls);
        checkOutput("postResetStalls", 32'(stalls), 32'd0);

        // Random mix of loads, stores and ALU ops with short ack delays
        for (int i = 0; i < 80; i++) begin
            kind  = $urandom_range(0, 2);
            rAddr = $urandom;
            rData = $urandom;
            rRead = $urandom;
            rPc   = $urandom;
            rRd   = 5'($urandom_range(0, 31));
            if (kind == 0) begin
                rF3 = loadCodes[$urandom_range(0, 7)];
                applyStimulus(1'b1, 2'b01, 1'b0, rF3, rAddr, rData, rRd, rPc,
                              $urandom_range(0, 5), rRead, stalls);
            end else if (kind == 1) begin
                rF3 = 3'($urandom_range(0, 2));
                applyStimulus(1'($urandom_range(0, 1)), 2'b00, 1'b1, rF3, rAddr, rData, rRd, rPc,
                              $urandom_range(0, 5), rRead, stalls);
            end else begin
                rSrc = $urandom_range(0, 1) ? 2'b10 : 2'b00;
                rF3  = 3'($urandom_range(0, 7));
                applyStimulus(1'($urandom_range(0, 1)), rSrc, 1'b0, rF3, rAddr, rData, rRd, rPc,
                              $urandom_range(0, 5), rRead, stalls);
                checkOutput("aluStalls", 32'(stalls), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
